// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction scheduler: data width, FSM
// state encoding and default slave-select timing in clk cycles.
package spi_pkg;

  localparam int DEF_LEN_DATA = 8;
  localparam int DEF_CS_SETUP = 4;
  localparam int DEF_CS_HOLD  = 4;
  localparam int DEF_CS_GAP   = 8;

  // Shared timer width; every timing constant must fit below 2**TMR_W.
  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot choice of the first request at or
// after the pointer (wrapping), pointer moves past the last owner on advance.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [NUM_REQ-1:0] last_grant,
  output logic [NUM_REQ-1:0] pick
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] pick_hi;
  logic [NUM_REQ-1:0] pick_lo;
  logic               found_hi;
  logic               found_lo;

  // pick_hi covers indices at/after the pointer; pick_lo is the wrap-around.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found_hi && (i >= int'(ptr_q))) begin
        pick_hi[i] = 1'b1;
        found_hi   = 1'b1;
      end
      if (req[i] && !found_lo) begin
        pick_lo[i] = 1'b1;
        found_lo   = 1'b1;
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_grant[i]) begin
        ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one byte-wide SPI engine among NUM_REQ requesters, running each
// multi-byte burst under its own slave select with setup/hold/gap timing.
module spi_txn_scheduler
  import spi_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int LEN_DATA  = DEF_LEN_DATA,
  parameter int LEN_BURST = 4,
  parameter int CS_SETUP  = DEF_CS_SETUP,
  parameter int CS_HOLD   = DEF_CS_HOLD,
  parameter int CS_GAP    = DEF_CS_GAP
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LEN_BURST-1:0]   burst_len,
  input  logic [NUM_REQ*LEN_DATA-1:0]    tx_data,
  output logic [NUM_REQ-1:0]             tx_pop,
  output logic [LEN_DATA-1:0]            rx_data,
  output logic [NUM_REQ-1:0]             rx_valid,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             ss_n,
  output logic                           eng_start,
  output logic [LEN_DATA-1:0]            eng_tx,
  input  logic                           eng_done,
  input  logic [LEN_DATA-1:0]            eng_rx,
  output state_e                         dbg_state
);

  // Handshakes: req is a level held until done; tx_pop, rx_valid, done,
  // eng_start and eng_done are single-cycle pulses with no back-pressure.
  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q;
  logic [TMR_W-1:0]     tmr_q;
  logic [LEN_BURST-1:0] cnt_q;
  logic [LEN_DATA-1:0]  eng_tx_q;
  logic [LEN_DATA-1:0]  rx_data_q;
  logic [NUM_REQ-1:0]   rx_valid_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   pick;
  logic [LEN_DATA-1:0]  sel_tx;
  logic [LEN_BURST-1:0] sel_len;
  logic                 hold_end;

  assign hold_end = (state_q == ST_HOLD) && (tmr_q == '0);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .advance    (hold_end),
    .last_grant (grant_q),
    .pick       (pick)
  );

  always_comb begin
    sel_tx  = '0;
    sel_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) sel_tx = tx_data[i*LEN_DATA +: LEN_DATA];
      if (pick[i])    sel_len = burst_len[i*LEN_BURST +: LEN_BURST];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|req) state_d = ST_SETUP;
      ST_SETUP: if (tmr_q == '0) state_d = ST_SEND;
      ST_SEND:  state_d = ST_WAIT;
      ST_WAIT:  if (eng_done) state_d = (cnt_q == LEN_BURST'(1)) ? ST_HOLD : ST_SEND;
      ST_HOLD:  if (tmr_q == '0) state_d = ST_GAP;
      ST_GAP:   if (tmr_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and timers; eng_done is only honoured in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      tmr_q      <= '0;
      cnt_q      <= '0;
      eng_tx_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= '0;
      done_q     <= '0;
    end else begin
      rx_valid_q <= '0;
      done_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant_q <= pick;
            cnt_q   <= (sel_len == '0) ? LEN_BURST'(1) : sel_len;
            tmr_q   <= TMR_W'(CS_SETUP - 1);
          end
        end
        ST_SETUP: if (tmr_q != '0) tmr_q <= tmr_q - TMR_W'(1);
        ST_SEND:  eng_tx_q <= sel_tx;
        ST_WAIT: begin
          if (eng_done) begin
            rx_data_q  <= eng_rx;
            rx_valid_q <= grant_q;
            cnt_q      <= cnt_q - LEN_BURST'(1);
            if (cnt_q == LEN_BURST'(1)) tmr_q <= TMR_W'(CS_HOLD - 1);
          end
        end
        ST_HOLD: begin
          if (tmr_q == '0) begin
            done_q  <= grant_q;
            grant_q <= '0;
            tmr_q   <= TMR_W'(CS_GAP - 1);
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_GAP:  if (tmr_q != '0) tmr_q <= tmr_q - TMR_W'(1);
        default: grant_q <= '0;
      endcase
    end
  end

  // Slave selects follow the registered grant, so at most one is ever low.
  assign ss_n      = ~grant_q;
  assign grant     = grant_q;
  assign eng_start = (state_q == ST_SEND);
  assign eng_tx    = (state_q == ST_SEND) ? sel_tx : eng_tx_q;
  assign tx_pop    = grant_q & {NUM_REQ{state_q == ST_SEND}};
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
